// File: rtl/button_request_arbiter_if.sv
// Button/LED bus for button_request_arbiter.
//   buttons : raw active-low push-buttons (0 = pressed), asynchronous
//   switch  : policy select, asynchronous (1 = fixed priority, 0 = round robin)
//   led     : {0, grant_idx+1} while granted, 0 otherwise
//   busy    : high while a grant is being shown
interface button_request_arbiter_if #(
  parameter int N = 8
);
  logic [N-1:0] buttons;
  logic         switch;
  logic [7:0]   led;
  logic         busy;

  modport master (output buttons, output switch, input led, input busy);
  modport slave  (input buttons, input switch, output led, output busy);
endinterface

// File: rtl/button_request_arbiter.sv
// button_request_arbiter: arbitrates one 8-bit LED display among N active-low
// push-buttons. Each button is synchronized and debounced; a debounced press
// latches a pending request. An IDLE/GRANT/GAP FSM grants one request at a time
// (fixed priority or round robin, chosen by the synchronized switch) and shows
// index+1 on led for HOLD_CYCLES cycles, followed by a one-cycle gap.
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : slave side of button_request_arbiter_if (buttons, switch, led, busy)

// Per-button 2-flop synchronizer + debouncer. fall pulses for one cycle after
// the debounced level goes 1->0.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw_n,
  output logic fall
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          s1, s2, deb, deb_d;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1    <= 1'b1;
      s2    <= 1'b1;
      deb   <= 1'b1;
      deb_d <= 1'b1;
      cnt   <= '0;
    end else begin
      s1    <= raw_n;
      s2    <= s1;
      deb_d <= deb;
      if (s2 != deb) begin
        // Flip on the DEBOUNCE_CYCLES-th consecutive differing cycle.
        if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
          deb <= s2;
          cnt <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  assign fall = deb_d & ~deb;
endmodule

module button_request_arbiter #(
  parameter int N               = 8,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HOLD_CYCLES     = 8
) (
  input logic                      clk,
  input logic                      reset_n,
  button_request_arbiter_if.slave  bus
);
  localparam int IW = $clog2(N);
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  state_t        state;
  logic [N-1:0]  fall, pend, clr;
  logic [IW-1:0] ptr, win;
  logic [HW-1:0] hold_cnt;
  logic          sw1, sw2;
  logic [7:0]    led_q;
  logic          busy_q;
  logic          grant_now;
  logic          found;
  int            j;

  genvar g;
  generate
    for (g = 0; g < N; g++) begin : g_btn
      button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
        .clk     (clk),
        .reset_n (reset_n),
        .raw_n   (bus.buttons[g]),
        .fall    (fall[g])
      );
    end
  endgenerate

  // Winner select: fixed = highest pending index; round robin = first pending
  // searching downward from ptr with wrap.
  always_comb begin
    win   = '0;
    found = 1'b0;
    j     = 0;
    if (sw2) begin
      for (int i = 0; i < N; i++)
        if (pend[i]) win = IW'(i);
    end else begin
      for (int k = 0; k < N; k++) begin
        j = int'(ptr) - k;
        if (j < 0) j = j + N;
        if (!found && pend[j]) begin
          win   = IW'(j);
          found = 1'b1;
        end
      end
    end
  end

  assign grant_now = (state == IDLE) && (pend != '0);
  assign clr       = grant_now ? (N'(1) << win) : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sw1  <= 1'b0;
      sw2  <= 1'b0;
      pend <= '0;
    end else begin
      sw1  <= bus.switch;
      sw2  <= sw1;
      // A new press in the same cycle as its clear keeps the request pending.
      pend <= (pend & ~clr) | fall;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      ptr      <= IW'(N - 1);
      hold_cnt <= '0;
      led_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (grant_now) begin
          hold_cnt <= HW'(HOLD_CYCLES - 1);
          led_q    <= 8'(win) + 8'd1;
          busy_q   <= 1'b1;
          ptr      <= (win == '0) ? IW'(N - 1) : win - IW'(1);
          state    <= GRANT;
        end
        GRANT: if (hold_cnt == '0) begin
          led_q  <= '0;
          busy_q <= 1'b0;
          state  <= GAP;
        end else begin
          hold_cnt <= hold_cnt - HW'(1);
        end
        GAP:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.led  = led_q;
  assign bus.busy = busy_q;
endmodule

// File: tb/tb_button_request_arbiter.sv
module tb_button_request_arbiter;
  localparam int N    = 8;
  localparam int HOLD = 8;

  typedef struct {
    logic [7:0] code;
    int         start;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n;
  int   cyc = 0;
  int   total = 0;
  int   pass = 0;
  int   c0, s0, nwait;
  exp_t q[$];

  button_request_arbiter_if #(.N(N)) bif ();

  button_request_arbiter #(.N(N), .DEBOUNCE_CYCLES(4), .HOLD_CYCLES(HOLD)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bif)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic expect_grant(input logic [7:0] code, input int start);
    exp_t e;
    e.code  = code;
    e.start = start;
    q.push_back(e);
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: each grant (busy rising) pops the next expected grant and checks
  // code, start cycle, steady led and hold length.
  logic       in_g = 1'b0;
  int         len = 0;
  logic [7:0] cur = '0;
  exp_t       me;

  always @(negedge clk) begin
    if (!reset_n) begin
      in_g = 1'b0;
      len  = 0;
    end else begin
      chk("led_vs_busy", int'(bif.led != 8'd0), int'(bif.busy));
      if (bif.busy && !in_g) begin
        in_g = 1'b1;
        len  = 1;
        cur  = bif.led;
        if (q.size() == 0) begin
          total++;
          $display("FAIL spurious_grant: led=%0d at cycle %0d, none expected", bif.led, cyc);
        end else begin
          me  = q.pop_front();
          cur = me.code;
          chk("grant_code", bif.led, me.code);
          chk("grant_start", cyc, me.start);
        end
      end else if (bif.busy && in_g) begin
        len++;
        chk("grant_hold_led", bif.led, cur);
      end else if (!bif.busy && in_g) begin
        in_g = 1'b0;
        chk("grant_length", len, HOLD);
      end
    end
  end

  initial begin
    bif.buttons = '1;
    bif.switch  = 1'b1;
    reset_n     = 1'b1;
    #2 reset_n  = 1'b0;
    wait_n(3);
    chk("reset_led", bif.led, 0);
    chk("reset_busy", bif.busy, 0);
    reset_n = 1'b1;

    // Idle with all buttons released.
    wait_n(20);
    chk("idle_led", bif.led, 0);
    chk("idle_busy", bif.busy, 0);

    // Fixed priority, single press of button 3.
    c0 = cyc;
    expect_grant(8'h04, c0 + 8);
    bif.buttons[3] = 1'b0;
    wait_n(12);
    bif.buttons = '1;
    wait_n(20);

    // Fixed priority, 5 and 2 together: 6 then 3, 10 cycles apart.
    c0 = cyc;
    expect_grant(8'h06, c0 + 8);
    expect_grant(8'h03, c0 + 18);
    bif.buttons[5] = 1'b0;
    bif.buttons[2] = 1'b0;
    wait_n(12);
    bif.buttons = '1;
    wait_n(30);

    // Reset mid-grant; a request pending at reset must be lost.
    c0 = cyc;
    expect_grant(8'h04, c0 + 8);
    bif.buttons[3] = 1'b0;
    nwait = 0;
    while (!bif.busy && nwait < 40) begin
      @(negedge clk);
      nwait++;
    end
    chk("rst_test_grant_seen", int'(bif.busy), 1);
    s0 = cyc;
    bif.buttons[1] = 1'b0;
    wait_n(7);
    chk("busy_before_reset", int'(bif.busy), 1);
    chk("reset_test_cycle", cyc, s0 + 7);
    #2 reset_n = 1'b0;
    bif.switch = 1'b0;
    #1;
    chk("async_reset_led", bif.led, 0);
    chk("async_reset_busy", bif.busy, 0);
    bif.buttons = '1;
    wait_n(3);
    reset_n = 1'b1;
    wait_n(30);
    chk("lost_pend_led", bif.led, 0);

    // Round robin, all pressed: 8,7,...,1.
    c0 = cyc;
    for (int k = 0; k < N; k++) expect_grant(8'(N - k), c0 + 8 + 10 * k);
    bif.buttons = '0;
    wait_n(12);
    bif.buttons = '1;
    wait_n(100);

    // Round robin, 7 and 0 together: pointer wrapped to 7 -> 8 then 1.
    c0 = cyc;
    expect_grant(8'h08, c0 + 8);
    expect_grant(8'h01, c0 + 18);
    bif.buttons[7] = 1'b0;
    bif.buttons[0] = 1'b0;
    wait_n(12);
    bif.buttons = '1;
    wait_n(30);

    // Bounce of 3 cycles is rejected; a 6-cycle press is accepted.
    bif.buttons[1] = 1'b0;
    wait_n(3);
    bif.buttons[1] = 1'b1;
    wait_n(20);
    chk("bounce_led", bif.led, 0);
    chk("bounce_busy", bif.busy, 0);
    c0 = cyc;
    expect_grant(8'h02, c0 + 8);
    bif.buttons[1] = 1'b0;
    wait_n(6);
    bif.buttons[1] = 1'b1;
    wait_n(25);

    // Grant to 4; button 6 pressed twice during it -> exactly one grant of 7.
    c0 = cyc;
    expect_grant(8'h05, c0 + 8);
    expect_grant(8'h07, c0 + 18);
    bif.buttons[4] = 1'b0;
    wait_n(2);
    bif.buttons[6] = 1'b0;
    wait_n(2);
    bif.buttons[4] = 1'b1;
    wait_n(2);
    bif.buttons[6] = 1'b1;
    wait_n(4);
    bif.buttons[6] = 1'b0;
    wait_n(4);
    bif.buttons[6] = 1'b1;
    wait_n(40);

    chk("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule

// File: doc/button_request_arbiter.md
Name: button_request_arbiter

Overview:
- Sequences access to the single 8-bit LED display among eight active-low push-buttons that act as requesters.
- Each button is synchronized and debounced; a debounced press latches a pending request.
- An FSM grants one request at a time, under fixed-priority or round-robin policy selected by the switch, and shows the winner on led for a fixed hold time.
- The LED code is the button index plus one; 0 means nothing is shown.

Parameters:
- N, 8: number of buttons/requesters. Legal range 2..15, so the code fits in led[3:0].
- DEBOUNCE_CYCLES, 4: consecutive stable cycles required to accept a level change. Must be >= 1.
- HOLD_CYCLES, 8: cycles a grant is held on led. Must be >= 1.

Ports:
- clk  in  1  system clock; all flops on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- buttons  in  N  raw, asynchronous, active-low push-buttons (0 = pressed).
- switch  in  1  policy select, asynchronous: 1 = fixed priority, 0 = round robin.
- led  out  8  {0, grant_idx+1} while granted; 0 otherwise.
- busy  out  1  high while in GRANT.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - sync flops and debounced state = all 1 (released); debounce counters = 0.
  - pend = 0; FSM = IDLE; rr pointer = N-1.
  - led = 0; busy = 0; switch synchronizer = 0.
- Synchronizer: 2 flops per button and 2 flops for switch.
- Debounce, per button:
  - Counter increments each cycle the synchronized value differs from the debounced state.
  - Counter clears on any cycle they agree.
  - On the DEBOUNCE_CYCLES-th consecutive differing cycle, the debounced state flips and the counter clears.
- Pending:
  - A debounced 1->0 transition sets pend[i] on the next edge.
  - A press while pend[i]=1 is absorbed (no queueing).
  - Releases never clear pend.
- Arbitration: evaluated only in IDLE, on the synchronized switch value.
  - Fixed (switch=1): the highest pending index wins.
  - Round robin (switch=0): search downward from ptr, wrapping N-1 after 0; the first pending index wins.
  - After any grant, ptr = (winner-1) mod N, in both modes.
- FSM:
  - IDLE: if pend != 0, latch grant_idx = winner, clear pend[winner], load hold_cnt = HOLD_CYCLES-1, go to GRANT. Otherwise stay.
  - GRANT: led = grant_idx+1, busy = 1. Decrement hold_cnt; when hold_cnt = 0, go to GAP. The grant lasts exactly HOLD_CYCLES cycles.
  - GAP: exactly 1 cycle; led = 0, busy = 0; then IDLE.
  - Minimum spacing between consecutive grants is HOLD_CYCLES+2 cycles (GAP, then IDLE decision).
- led and busy are registered outputs driven from FSM state.
- Latency, press to display: button low at edge 0 gives led valid after edge DEBOUNCE_CYCLES+3 (7 at default), assuming IDLE and no contention.
- Boundary cases:
  - New debounced press of the winner in the same cycle its pend is cleared: set wins, and the request stays pending.
  - Presses during GRANT/GAP latch into pend and are arbitrated at the next IDLE.
  - Switch changes during GRANT do not affect the current grant.
  - Button bounce shorter than DEBOUNCE_CYCLES is never accepted.
  - Reset asserted mid-GRANT forces led = 0 and busy = 0 immediately; all pending requests are lost.
  - All N buttons pressed simultaneously in round robin: each is granted once, in descending-index order, before any index repeats.

Test Plan:
- Reset, then buttons = 8'hFF -> led = 0 and busy = 0 indefinitely; reset_n low mid-GRANT -> led = 0 asynchronously.
- switch = 1, buttons[3] held low -> led = 8'h04 from edge 7 for 8 cycles, then 0 for the GAP cycle; busy mirrors the grant.
- switch = 1, buttons[5] and buttons[2] pressed together -> led = 8'h06 for 8 cycles, 1 gap cycle, led = 0 during the IDLE decision cycle, then led = 8'h03 for 8 cycles.
- switch = 0, all buttons pressed together -> grant sequence 8,7,6,...,1. Then press buttons[7] and buttons[0] together -> grant order 8 then 1.
- buttons[1] toggles low for 3 cycles then high (bounce) -> pend never set and led stays 0. The same button held low for 4+ cycles -> led = 8'h02.
- During a grant to index 4, press buttons[6] twice with full debounce -> exactly one later grant led = 8'h07 (absorbed duplicate).
